reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares one WIDTH-bit holding register (clocked data_in/data_out register style) among NUM_REQ requesters.
- Round-robin arbitration; loads the winner's data into the register and acknowledges with a one-cycle pulse.
- Enforces a fixed hold window after every write, so each value is stable for at least HOLD_CYCLES+1 cycles before it can be overwritten.
- Sits between requesting blocks and downstream logic that consumes data_out.

Parameters:
- WIDTH, 8, data width of the shared register.
- NUM_REQ, 4, number of requesters; must be at least 2.
- HOLD_CYCLES, 2, cycles spent in HOLD after each write; must be at least 1.
- OWNER_W, $clog2(NUM_REQ), width of owner; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  NUM_REQ  level request, one bit per requester.
- req_data  input  NUM_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the requester whose data was loaded.
- data_out  output  WIDTH  current contents of the shared register.
- owner  output  OWNER_W  index of the last requester written.
- data_valid  output  1  0 after reset; 1 after the first write, then sticky.
- busy  output  1  1 while state is HOLD.
- write_count  output  16  number of writes since reset; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect at any point including mid-HOLD):
  - data_out=0, owner=0, ack=0, data_valid=0, busy=0, write_count=0.
  - rr_ptr=0, hold counter=0, state=IDLE.
  - No ack is issued for an interrupted operation.
- State IDLE: req is sampled only in this state.
  - If req is nonzero at a rising edge, pick the winner: the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At that same edge: data_out <= winner's req_data; owner <= winner; ack <= one-hot(winner); data_valid <= 1; write_count <= write_count+1; rr_ptr <= (winner+1) mod NUM_REQ; counter <= HOLD_CYCLES-1; state <= HOLD.
  - If req is zero, nothing changes and ack stays 0.
- State HOLD:
  - busy=1 for exactly HOLD_CYCLES cycles.
  - ack is high only during the first HOLD cycle, then returns to 0.
  - req and req_data are ignored.
  - Counter decrements each edge; when it reaches 0, state <= IDLE.
- Latency and throughput:
  - req high at edge k gives data_out updated after edge k and ack high during cycle k..k+1.
  - Maximum rate is one write per HOLD_CYCLES+1 cycles.
- Handshake:
  - A requester keeps req and req_data stable until it sees ack.
  - A requester that keeps req high after its ack competes again at the next IDLE; round-robin guarantees it yields to any other pending requester.
  - req dropped before it is sampled in IDLE produces no write.
- Simultaneous requests are resolved purely by rr_ptr. With rr_ptr=0 after reset, requester 0 has highest priority.
- req_data of non-winning requesters never affects any output.
- data_out and owner hold their values indefinitely between writes.
- There is no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset: assert rst_n=0 with req=4'b1111 -> all outputs 0, no ack. Release -> first grant goes to requester 0.
2. Single request: req=4'b0010, data1=8'h05 -> after one edge data_out=8'h05, owner=1, ack=4'b0010 for 1 cycle, busy=1 for 2 cycles, data_valid=1, write_count=1.
3. All requesters held high with data 8'h11/8'h22/8'h33/8'h44 -> grant order 0,1,2,3,0, one grant every 3 cycles. data_out follows 11,22,33,44,11; write_count=5.
4. Fairness: after a grant to 2, raise req0 and req3 together -> 3 wins first (data 8'h0A, owner=3), then 0.
5. Mid-HOLD reset: pull rst_n low one cycle into HOLD -> immediate clear with no further ack. After release, req=4'b0100 -> owner=2, write_count=1.
6. Ignored in HOLD: pulse req3 only during HOLD and drop it before IDLE -> no grant; data_out and write_count unchanged.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares one WIDTH-bit holding register among NUM_REQ requesters.
//   Round-robin arbitration picks a winner in IDLE. The winner's data is loaded
//   and it gets a one-cycle ack. The register is then held for HOLD_CYCLES cycles
//   before the next request is sampled.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          level request, one bit per requester
//   req_data     packed write data, requester i at [i*WIDTH +: WIDTH]
//   ack          one-hot, one-cycle pulse to the requester just loaded
//   data_out     shared register contents
//   owner        index of the last requester written
//   data_valid   sticky, set by the first write after reset
//   busy         high while in the hold window
//   write_count  writes since reset, wraps at 16 bits
module reg_write_arbiter #(
   parameter int WIDTH       = 8,
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 2,
   parameter int OWNER_W     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       ack,
   output logic [WIDTH-1:0]         data_out,
   output logic [OWNER_W-1:0]       owner,
   output logic                     data_valid,
   output logic                     busy,
   output logic [15:0]              write_count
);

   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state, state_nxt;
   logic [OWNER_W-1:0] rr_ptr;
   logic [OWNER_W-1:0] win;
   logic               win_vld;
   logic               grant;
   logic [CNT_W-1:0]   cnt;

   // First set request bit at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      idx     = 0;
      win     = '0;
      win_vld = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = (int'(rr_ptr) + off) % NUM_REQ;
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win     = OWNER_W'(idx);
         end
      end
   end

   // Next-state logic. Requests are looked at only in IDLE.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt = HOLD;
               grant     = 1'b1;
            end
         end
         HOLD: begin
            if (cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= '0;
         owner       <= '0;
         ack         <= '0;
         data_valid  <= 1'b0;
         write_count <= '0;
         rr_ptr      <= '0;
         cnt         <= '0;
      end else begin
         ack <= '0;
         if (grant) begin
            data_out    <= req_data[win*WIDTH +: WIDTH];
            owner       <= win;
            ack         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            data_valid  <= 1'b1;
            write_count <= write_count + 16'd1;
            // The winner moves to lowest priority for the next round.
            rr_ptr      <= (win == OWNER_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
            cnt         <= CNT_W'(HOLD_CYCLES-1);
         end else if (state == HOLD && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // The state is a flop, so busy is still a registered output.
   assign busy = (state == HOLD);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      data_out;
   logic [1:0]            owner;
   logic                  data_valid;
   logic                  busy;
   logic [15:0]           write_count;

   reg_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
      .data_out(data_out), .owner(owner), .data_valid(data_valid),
      .busy(busy), .write_count(write_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ack;
      logic [7:0]  data;
      logic [1:0]  owner;
      logic [15:0] wc;
      int          gap;   // required cycles since previous grant, 0 = any
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_grant_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [7:0] d, input logic [1:0] o,
                       input logic [15:0] w, input int g);
      exp_t e;
      e.ack = a; e.data = d; e.owner = o; e.wc = w; e.gap = g;
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_data_out"}, 32'(data_out), 32'h0);
      chk({tag, "_owner"}, 32'(owner), 32'h0);
      chk({tag, "_ack"}, 32'(ack), 32'h0);
      chk({tag, "_valid"}, 32'(data_valid), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_wc"}, 32'(write_count), 32'h0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every ack seen is matched against the oldest expected grant.
   always @(negedge clk) begin
      if (rst_n && ack != '0) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("grant_ack", 32'(ack), 32'(e.ack));
            chk("grant_data", 32'(data_out), 32'(e.data));
            chk("grant_owner", 32'(owner), 32'(e.owner));
            chk("grant_wc", 32'(write_count), 32'(e.wc));
            chk("grant_valid", 32'(data_valid), 32'h1);
            chk("grant_busy", 32'(busy), 32'h1);
            if (e.gap != 0) chk("grant_gap", 32'(cyc - last_grant_cyc), 32'(e.gap));
         end
         last_grant_cyc = cyc;
      end
   end

   initial begin
      // Reset with every requester asserted.
      rst_n    = 1'b0;
      req      = 4'b1111;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      tick(3);
      chk_reset_state("rst");

      // Release: round robin 0,1,2,3,0, one grant every 3 cycles.
      push(4'b0001, 8'h11, 2'd0, 16'd1, 0);
      push(4'b0010, 8'h22, 2'd1, 16'd2, 3);
      push(4'b0100, 8'h33, 2'd2, 16'd3, 3);
      push(4'b1000, 8'h44, 2'd3, 16'd4, 3);
      push(4'b0001, 8'h11, 2'd0, 16'd5, 3);
      rst_n = 1'b1;
      tick(1);
      chk("rr_busy_c1", 32'(busy), 32'h1);
      tick(1);
      chk("rr_busy_c2", 32'(busy), 32'h1);
      chk("rr_ack_c2", 32'(ack), 32'h0);
      tick(1);
      chk("rr_busy_c3", 32'(busy), 32'h0);
      tick(10);                 // fifth grant just happened
      req = '0;
      tick(3);
      chk("rr_final_data", 32'(data_out), 32'h11);
      chk("rr_final_wc", 32'(write_count), 32'd5);

      // Single request after a fresh reset.
      rst_n = 1'b0;
      #1;
      chk_reset_state("rst2");
      rst_n = 1'b1;
      req_data = {8'h00, 8'h00, 8'h05, 8'h00};
      push(4'b0010, 8'h05, 2'd1, 16'd1, 0);
      req = 4'b0010;
      tick(1);
      req = '0;
      chk("single_valid", 32'(data_valid), 32'h1);
      tick(1);
      chk("single_busy_c2", 32'(busy), 32'h1);
      chk("single_ack_c2", 32'(ack), 32'h0);
      tick(1);
      chk("single_busy_c3", 32'(busy), 32'h0);

      // Fairness: grant to 2, then 0 and 3 together -> 3 first, then 0.
      req_data = {8'h0A, 8'h77, 8'h00, 8'hB0};
      push(4'b0100, 8'h77, 2'd2, 16'd2, 0);
      req = 4'b0100;
      tick(1);
      req = '0;
      tick(2);
      push(4'b1000, 8'h0A, 2'd3, 16'd3, 0);
      push(4'b0001, 8'hB0, 2'd0, 16'd4, 3);
      req = 4'b1001;
      tick(1);
      req = 4'b0001;            // requester 3 saw its ack and drops
      tick(3);
      req = '0;
      tick(2);

      // Requests only during HOLD are ignored.
      req_data = {8'hEE, 8'h00, 8'h3C, 8'h00};
      push(4'b0010, 8'h3C, 2'd1, 16'd5, 0);
      req = 4'b0010;
      tick(1);
      req = 4'b1000;
      tick(2);
      req = '0;
      tick(4);
      chk("hold_ign_data", 32'(data_out), 32'h3C);
      chk("hold_ign_wc", 32'(write_count), 32'd5);
      chk("hold_ign_owner", 32'(owner), 32'd1);

      // Reset one cycle into HOLD clears everything immediately.
      req_data = {8'h00, 8'h99, 8'h55, 8'h00};
      push(4'b0010, 8'h55, 2'd1, 16'd6, 0);
      req = 4'b0010;
      tick(1);
      req = '0;
      tick(1);
      rst_n = 1'b0;
      #1;
      chk_reset_state("midhold");
      tick(2);
      chk("midhold_ack", 32'(ack), 32'h0);
      rst_n = 1'b1;
      push(4'b0100, 8'h99, 2'd2, 16'd1, 0);
      req = 4'b0100;
      tick(1);
      req = '0;
      tick(4);
      chk("post_rst_owner", 32'(owner), 32'd2);
      chk("post_rst_wc", 32'(write_count), 32'd1);

      // Every expected grant must have been observed.
      chk("pending_grants", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
